// File: rtl/spi_flash_loader_if.sv
// Board-side pins of the boot loader: SPI flash bus and SRAM write port.
interface spi_flash_loader_if;
    logic        flash_cs_n_o;
    logic        flash_sclk_o;
    logic        flash_mosi_o;
    logic        flash_miso_i;
    logic [20:0] sram_addr_o;
    logic [7:0]  sram_data_o;
    logic        sram_we_n_o;

    modport master (
        output flash_cs_n_o, flash_sclk_o, flash_mosi_o,
        output sram_addr_o, sram_data_o, sram_we_n_o,
        input  flash_miso_i
    );

    modport slave (
        input  flash_cs_n_o, flash_sclk_o, flash_mosi_o,
        input  sram_addr_o, sram_data_o, sram_we_n_o,
        output flash_miso_i
    );
endinterface

// File: rtl/spi_flash_loader.sv
// Copies a fixed image from SPI flash (READ 03h, mode 0) into 8-bit SRAM,
// holding the system core in reset until the copy is complete.
module spi_flash_loader #(
    parameter logic [23:0] FLASH_ADDR = 24'h100000,
    parameter logic [20:0] SRAM_BASE  = 21'h0F0000,
    parameter int unsigned LENGTH     = 65536,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned STARTUP    = 1000
) (
    input  logic               clk_chipset,
    input  logic               reset_n,
    spi_flash_loader_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               sys_reset_n
);
    typedef enum logic [2:0] {
        S_WAIT,
        S_CMD,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [31:0] START_CNT = 32'(STARTUP);
    localparam logic [15:0] DIV_MAX   = 16'(CLK_DIV - 1);
    localparam logic [20:0] LEN       = 21'(LENGTH);
    localparam logic [31:0] READ_CMD  = {8'h03, FLASH_ADDR};

    state_t      state;
    state_t      state_nx;
    logic [31:0] wait_cnt;
    logic [31:0] shreg;
    logic [15:0] div_cnt;
    logic [4:0]  bit_cnt;
    logic [1:0]  we_cnt;
    logic [7:0]  rx;
    logic [20:0] byte_cnt;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        we_n;
    logic [20:0] addr;
    logic [7:0]  data;
    logic        tick;
    logic        rise;
    logic        fall;
    logic        last;

    assign bus.flash_cs_n_o = cs_n;
    assign bus.flash_sclk_o = sclk;
    assign bus.flash_mosi_o = mosi;
    assign bus.sram_addr_o  = addr;
    assign bus.sram_data_o  = data;
    assign bus.sram_we_n_o  = we_n;

    always_ff @(posedge clk_chipset or negedge reset_n) begin
        if (!reset_n) state <= S_WAIT;
        else          state <= state_nx;
    end

    always_comb begin
        tick     = div_cnt == DIV_MAX;
        rise     = tick && !sclk;
        fall     = tick && sclk;
        last     = (byte_cnt + 21'd1) == LEN;
        state_nx = state;
        unique case (state)
            S_WAIT:  if (wait_cnt == START_CNT) state_nx = S_CMD;
            S_CMD:   if (fall && bit_cnt == 5'd31) state_nx = S_DATA;
            S_DATA:  if (fall && bit_cnt == 5'd7) state_nx = S_WRITE;
            S_WRITE: if (we_cnt == 2'd3) state_nx = last ? S_DONE : S_DATA;
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_WAIT;
        endcase
    end

    always_ff @(posedge clk_chipset or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt    <= '0;
            shreg       <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            we_cnt      <= '0;
            rx          <= '0;
            byte_cnt    <= '0;
            cs_n        <= 1'b1;
            sclk        <= 1'b0;
            mosi        <= 1'b0;
            we_n        <= 1'b1;
            addr        <= SRAM_BASE;
            data        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sys_reset_n <= 1'b0;
        end else begin
            sys_reset_n <= done;
            unique case (state)
                S_WAIT: begin
                    if (state_nx == S_CMD) begin
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        shreg   <= READ_CMD;
                        mosi    <= READ_CMD[31];
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_CMD, S_DATA: begin
                    div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
                    if (tick) sclk <= ~sclk;
                    if (rise && state == S_DATA) rx <= {rx[6:0], bus.flash_miso_i};
                    // MOSI moves only on falling edges so it is stable while SCLK is high
                    if (fall) begin
                        bit_cnt <= (state_nx != state) ? 5'd0 : bit_cnt + 5'd1;
                        if (state == S_CMD) begin
                            shreg <= shreg << 1;
                            mosi  <= (bit_cnt == 5'd31) ? 1'b0 : shreg[30];
                        end else if (state_nx == S_WRITE) begin
                            data   <= rx;
                            we_cnt <= '0;
                        end
                    end
                end
                S_WRITE: begin
                    we_cnt <= we_cnt + 2'd1;
                    we_n   <= !(we_cnt == 2'd0 || we_cnt == 2'd1);
                    if (we_cnt == 2'd3) begin
                        addr     <= addr + 21'd1;
                        byte_cnt <= byte_cnt + 21'd1;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        if (last) begin
                            cs_n <= 1'b1;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    cs_n <= 1'b1;
                    sclk <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_loader.sv
// Directed bench: five loader configurations run one after another against a
// shared SPI flash model, with an SRAM write scoreboard and protocol monitor.
module tb_spi_flash_loader;
  localparam int N = 5;
  localparam int ST = 10;

  typedef struct packed {
    logic [20:0] a;
    logic [7:0]  d;
  } wr_t;

  function automatic int cfg_len(input int c);
    case (c)
      0: return 4;
      1: return 2;
      2: return 2;
      3: return 8;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_cd(input int c);
    case (c)
      0: return 2;
      1: return 1;
      2: return 3;
      3: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [20:0] cfg_sb(input int c);
    return (c == 4) ? 21'h1FFFFE : 21'h0F0000;
  endfunction

  function automatic logic [23:0] cfg_fa(input int c);
    return (c == 1) ? 24'hABCDEF : 24'h100000;
  endfunction

  function automatic logic [7:0] img(input int c, input int i);
    logic [31:0] t;
    t = 32'hA55A00FF;
    if (c == 0 && i < 4) return t[31-8*i -: 8];
    return 8'(i * 53 + c * 29 + 7);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       rst_n_v;
  logic [N-1:0]       cs_v, sclk_v, mosi_v, we_v;
  logic [N-1:0]       busy_v, done_v, sysr_v;
  logic [N-1:0][20:0] addr_v;
  logic [N-1:0][7:0]  data_v;
  logic               miso = 1'b0;
  int                 cur;

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_flash_loader_if bus ();
    assign bus.flash_miso_i = miso;
    spi_flash_loader #(
      .FLASH_ADDR(cfg_fa(g)),
      .SRAM_BASE (cfg_sb(g)),
      .LENGTH    (cfg_len(g)),
      .CLK_DIV   (cfg_cd(g)),
      .STARTUP   (ST)
    ) dut (
      .clk_chipset(clk),
      .reset_n    (rst_n_v[g]),
      .bus        (bus),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .sys_reset_n(sysr_v[g])
    );
    assign cs_v[g]   = bus.flash_cs_n_o;
    assign sclk_v[g] = bus.flash_sclk_o;
    assign mosi_v[g] = bus.flash_mosi_o;
    assign we_v[g]   = bus.sram_we_n_o;
    assign addr_v[g] = bus.sram_addr_o;
    assign data_v[g] = bus.sram_data_o;
  end

  logic        cs_s, sclk_s, mosi_s, we_s;
  logic        busy_s, done_s, sysr_s;
  logic [20:0] addr_s;
  logic [7:0]  data_s;
  assign cs_s   = cs_v[cur];
  assign sclk_s = sclk_v[cur];
  assign mosi_s = mosi_v[cur];
  assign we_s   = we_v[cur];
  assign busy_s = busy_v[cur];
  assign done_s = done_v[cur];
  assign sysr_s = sysr_v[cur];
  assign addr_s = addr_v[cur];
  assign data_s = data_v[cur];

  int  checks;
  int  errors;
  wr_t exp_q[$];

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] expv
  );
    checks++;
    if (obs !== expv) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  int          fbit = 0;
  logic [31:0] fcmd = '0;
  always @(negedge cs_s) begin
    fbit = 0;
    fcmd = '0;
  end
  always @(posedge sclk_s) begin
    if (!cs_s) begin
      if (fbit < 32) fcmd = {fcmd[30:0], mosi_s};
      fbit++;
    end
  end
  always @(negedge sclk_s) begin
    logic [7:0] b;
    int         k;
    if (!cs_s && fbit >= 32) begin
      k    = fbit - 32;
      b    = img(cur, k / 8);
      miso = b[7 - (k % 8)];
    end
  end

  logic        mon_en = 1'b0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  logic        prev_mosi = 1'b0, prev_we = 1'b1;
  logic [20:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;
  int          lo_len = 0, hi_len = 0;
  int          we_len = 0, pulses = 0;
  bit          we_seen = 1'b0;
  wr_t         e_m;

  always @(negedge clk) begin
    if (mon_en) begin
      if (cs_s) chk("sclk_idle_cs_high", sclk_s, 1'b0);
      if (busy_s) chk("cs_low_while_busy", cs_s, 1'b0);
      if (!we_s) begin
        chk("we_vs_sclk_high", sclk_s, 1'b0);
        we_seen = 1'b1;
      end
      if (sclk_s && prev_sclk)
        chk("mosi_stable", mosi_s, prev_mosi);
      if (!cs_s && prev_cs) begin
        lo_len  = 0;
        we_seen = 1'b0;
      end
      if (sclk_s && !prev_sclk && !we_seen)
        chk("sclk_low_half", lo_len, cfg_cd(cur));
      if (!sclk_s && prev_sclk) begin
        if (!cs_s)
          chk("sclk_high_half", hi_len, cfg_cd(cur));
        lo_len  = 0;
        we_seen = 1'b0;
      end
      if (sclk_s && !prev_sclk) hi_len = 0;
      if (sclk_s) hi_len++;
      else lo_len++;
      if (!we_s && prev_we) begin
        pulses++;
        we_len = 0;
        chk("we_setup_addr", addr_s, prev_addr);
        chk("we_setup_data", data_s, prev_data);
        chk("sb_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e_m = exp_q.pop_front();
          chk("wr_addr", addr_s, e_m.a);
          chk("wr_data", data_s, e_m.d);
        end
      end
      if (we_s && !prev_we) begin
        chk("we_width", we_len, 2);
        chk("we_hold_addr", addr_s, prev_addr);
        chk("we_hold_data", data_s, prev_data);
      end
      if (!we_s) we_len++;
    end
    prev_cs   = cs_s;
    prev_sclk = sclk_s;
    prev_mosi = mosi_s;
    prev_we   = we_s;
    prev_addr = addr_s;
    prev_data = data_s;
  end

  task automatic check_reset(input logic [20:0] sb);
    chk("rst_cs_n", cs_s, 1'b1);
    chk("rst_sclk", sclk_s, 1'b0);
    chk("rst_mosi", mosi_s, 1'b0);
    chk("rst_addr", addr_s, sb);
    chk("rst_data", data_s, 8'h00);
    chk("rst_we_n", we_s, 1'b1);
    chk("rst_busy", busy_s, 1'b0);
    chk("rst_done", done_s, 1'b0);
    chk("rst_sys_reset_n", sysr_s, 1'b0);
  endtask

  task automatic push_exp(input int c);
    wr_t w;
    for (int i = 0; i < cfg_len(c); i++) begin
      w.a = 21'(cfg_sb(c) + 21'(i));
      w.d = img(c, i);
      exp_q.push_back(w);
    end
  endtask

  task automatic release_and_finish(input int c);
    int cd;
    int exp_cyc;
    int cyc;
    cd      = cfg_cd(c);
    exp_cyc = ST + 1 + 64 * cd
            + cfg_len(c) * (16 * cd + 4);
    cyc     = 0;
    @(negedge clk);
    rst_n_v[c] = 1'b1;
    while (!done_s && cyc < exp_cyc + 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("total_cycles", cyc, exp_cyc);
    chk("done_rise", done_s, 1'b1);
    chk("busy_at_done", busy_s, 1'b0);
    chk("sys_reset_n_lag", sysr_s, 1'b0);
    chk("read_cmd", fcmd, {8'h03, cfg_fa(c)});
    @(posedge clk);
    #1;
    chk("sys_reset_n_rise", sysr_s, 1'b1);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    int p0;
    int n;
    checks  = 0;
    errors  = 0;
    cur     = 0;
    rst_n_v = '0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    check_reset(cfg_sb(0));

    push_exp(0);
    release_and_finish(0);
    p0 = pulses;
    repeat (1000) @(negedge clk);
    chk("hold_cs_n", cs_s, 1'b1);
    chk("hold_sclk", sclk_s, 1'b0);
    chk("hold_done", done_s, 1'b1);
    chk("hold_busy", busy_s, 1'b0);
    chk("hold_no_we", pulses, p0);

    @(negedge clk);
    cur = 1;
    push_exp(1);
    release_and_finish(1);

    @(negedge clk);
    cur = 2;
    push_exp(2);
    release_and_finish(2);

    @(negedge clk);
    cur = 3;
    push_exp(3);
    @(negedge clk);
    rst_n_v[3] = 1'b1;
    n = 0;
    while (exp_q.size() > 6 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("byte3_reached", exp_q.size(), 6);
    repeat (10) @(posedge clk);
    #2;
    rst_n_v[3] = 1'b0;
    #1;
    check_reset(cfg_sb(3));
    exp_q.delete();
    push_exp(3);
    repeat (3) @(posedge clk);
    release_and_finish(3);

    @(negedge clk);
    cur = 4;
    push_exp(4);
    release_and_finish(4);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_flash_loader.md
# spi_flash_loader

Boot-time loader that copies a fixed-length image (BIOS/option ROM) from the board's SPI flash into the external 8-bit SRAM before the PCXT system starts. It sits between the board pins (flash_*_o, ram_*_o) and the system core. It drives the flash SPI bus and the SRAM write port, and holds the system in reset until the copy completes. After `done`, the top level returns SRAM address, data and write control to the system.

## Interface

Parameters:
- FLASH_ADDR, 24'h100000: first flash byte address of the image.
- SRAM_BASE, 21'h0F0000: first SRAM byte address written.
- LENGTH, 65536: bytes to copy; range 1..2^20.
- CLK_DIV, 2: clk cycles per SCLK half-period; minimum 1.
- STARTUP, 1000: clk cycles to wait after reset release before CS_n falls (flash power-up).

Ports:
- clk_chipset, in, 1: system clock (50 MHz).
- reset_n, in, 1: asynchronous, active-low reset.
- flash_cs_n_o, out, 1: flash chip select, active low.
- flash_sclk_o, out, 1: SPI clock, mode 0 (idle low).
- flash_mosi_o, out, 1: command/address out, MSB first.
- flash_miso_i, in, 1: data in, sampled on SCLK rising edge.
- sram_addr_o, out, 21: SRAM write address.
- sram_data_o, out, 8: SRAM write data.
- sram_we_n_o, out, 1: SRAM write strobe, active low.
- busy, out, 1: copy in progress.
- done, out, 1: copy complete; sticky until reset.
- sys_reset_n, out, 1: reset to the system core, low until done.

## Operation

- Reset values: flash_cs_n_o=1, flash_sclk_o=0, flash_mosi_o=0, sram_addr_o=SRAM_BASE, sram_data_o=0, sram_we_n_o=1, busy=0, done=0, sys_reset_n=0.
- States: WAIT, CMD, DATA, WRITE, DONE.
- WAIT: count STARTUP cycles, then assert cs_n and busy, load shift register {8'h03, FLASH_ADDR}, and go to CMD.
- CMD: shift 32 bits out on MOSI. MOSI changes only while SCLK is low. After the 32nd falling edge, go to DATA. MOSI is don't-care afterwards and is held 0.
- DATA: 8 SCLK periods. MISO is shifted in MSB first on each rising edge. After the 8th falling edge, present the byte on sram_data_o and go to WRITE. SCLK stays low in WRITE; the pause is legal in mode 0.
- WRITE: sram_we_n_o low for exactly 2 clk cycles, with address and data stable 1 cycle before and 1 cycle after the strobe (4 cycles total). Then increment sram_addr_o and the byte counter.
  - If count == LENGTH: go to DONE.
  - Otherwise: resume DATA. No new command is issued; the flash read auto-increments.
- DONE: cs_n=1, SCLK=0, busy=0, done=1. sys_reset_n rises 1 cycle after done. Remains in DONE until reset.
- Byte counter is 21 bits. sram_addr_o wraps modulo 2^21 with no error.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronously). On release, the copy restarts from WAIT. No partial state is retained.

## Timing

- SCLK period: 2·CLK_DIV clk cycles, 50 % duty.
- First rising edge: CLK_DIV cycles after cs_n falls.
- Per byte: 16·CLK_DIV + 4 cycles.
- Total from reset release to done: STARTUP + 1 + 64·CLK_DIV + LENGTH·(16·CLK_DIV+4) cycles, ±1.
- MISO is sampled in the clk cycle where SCLK goes 0→1.
- sram_we_n_o never overlaps an SCLK high phase.
- sys_reset_n is registered and glitch-free.

## Test plan

- Basic copy: LENGTH=4, CLK_DIV=2, STARTUP=10, FLASH_ADDR=24'h100000, flash model returns A5,5A,00,FF. Required response:
  - MOSI bits decode to 03 10 00 00.
  - SRAM writes are F0000=A5, F0001=5A, F0002=00, F0003=FF.
  - done rises; sys_reset_n rises 1 cycle later.
- Timing check: CLK_DIV=1 and CLK_DIV=3, LENGTH=2. Measure SCLK half-period (1 and 3 cycles), the 2-cycle WE low pulse, and the total cycle count against the formula.
- Reset mid-copy: LENGTH=8, assert reset_n during byte 3. Outputs must return to reset values the same cycle. After release, a fresh 03 command is issued and all 8 bytes are rewritten from F0000.
- Hold after done: run 1000 extra cycles after done. Required: cs_n=1, no further WE pulses, done=1, busy=0.
- Address wrap: SRAM_BASE=21'h1FFFFE, LENGTH=4. Writes must land at 1FFFFE, 1FFFFF, 000000, 000001.
- Protocol checker (all runs): MOSI stable while SCLK high, cs_n low for the whole transfer, no SCLK edges while cs_n high.
